// File: rtl/writeback_stage.sv
// MEM->WB pipeline register with load alignment/extension, result select,
// variable-latency load stall and a retired-instruction counter.
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic [DATA_WIDTH-1:0] ExtImmM,
  input  logic [2:0]            AddressingControlM,
  input  logic [DATA_WIDTH-1:0] ReadDataM,
  input  logic                  MemRValidM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic [CNT_WIDTH-1:0]  RetiredW
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t                state;
  logic                  load_m;
  logic                  cap;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_val;
  logic [DATA_WIDTH-1:0] res_m;

  assign load_m = ValidM & (ResultSrcM == 2'b01);
  // In WAIT the held instruction is the pending load, so only MemRValidM matters.
  assign StallM = rst_n & ((state == S_WAIT) | load_m) & ~MemRValidM;
  assign cap    = ValidM & ~StallM;

  always_comb begin
    ld_b = ReadDataM[7:0];
    case (ALUResultM[1:0])
      2'd1:    ld_b = ReadDataM[15:8];
      2'd2:    ld_b = ReadDataM[23:16];
      2'd3:    ld_b = ReadDataM[31:24];
      default: ld_b = ReadDataM[7:0];
    endcase
    ld_h = ALUResultM[1] ? ReadDataM[31:16] : ReadDataM[15:0];
    case (AddressingControlM)
      3'b000:  ld_val = {{(DATA_WIDTH-8){ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{(DATA_WIDTH-16){ld_h[15]}}, ld_h};
      3'b100:  ld_val = {{(DATA_WIDTH-8){1'b0}}, ld_b};
      3'b101:  ld_val = {{(DATA_WIDTH-16){1'b0}}, ld_h};
      default: ld_val = ReadDataM;
    endcase
  end

  always_comb begin
    case (ResultSrcM)
      2'b01:   res_m = ld_val;
      2'b10:   res_m = PCPlus4M;
      2'b11:   res_m = ExtImmM;
      default: res_m = ALUResultM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      ResultW   <= '0;
      RdW       <= '0;
      RegWriteW <= 1'b0;
      RetiredW  <= '0;
    end else begin
      state <= StallM ? S_WAIT : S_RUN;
      if (cap) begin
        ResultW   <= res_m;
        RdW       <= RdM;
        RegWriteW <= RegWriteM & (RdM != 5'd0);
        RetiredW  <= RetiredW + CNT_WIDTH'(1);
      end else begin
        RegWriteW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus pushes expected W-stage
// results, a negedge monitor pops one whenever RetiredW advances.
module tb_writeback_stage;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ValidM, RegWriteM, MemRValidM;
  logic [1:0]    ResultSrcM;
  logic [4:0]    RdM;
  logic [DW-1:0] ALUResultM, PCPlus4M, ExtImmM, ReadDataM;
  logic [2:0]    AddressingControlM;
  logic          StallM, RegWriteW;
  logic [DW-1:0] ResultW;
  logic [4:0]    RdW;
  logic [CW-1:0] RetiredW;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [4:0]    rd;
    logic          we;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] exp_ret;
  logic [CW-1:0] prev_ret;
  int            checks = 0;
  int            errs   = 0;

  writeback_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM),
    .PCPlus4M(PCPlus4M), .ExtImmM(ExtImmM),
    .AddressingControlM(AddressingControlM), .ReadDataM(ReadDataM),
    .MemRValidM(MemRValidM), .StallM(StallM), .ResultW(ResultW), .RdW(RdW),
    .RegWriteW(RegWriteW), .RetiredW(RetiredW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ValidM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 2'b00; RdM = '0;
    ALUResultM = '0; PCPlus4M = '0; ExtImmM = '0; AddressingControlM = '0;
    ReadDataM = '0; MemRValidM = 1'b0;
  endtask

  task automatic drive(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] pc4,
                       input logic [DW-1:0] imm, input logic [2:0] f3,
                       input logic [DW-1:0] rdata, input logic mv);
    ValidM = 1'b1; RegWriteM = rw; ResultSrcM = src; RdM = rd; ALUResultM = alu;
    PCPlus4M = pc4; ExtImmM = imm; AddressingControlM = f3; ReadDataM = rdata;
    MemRValidM = mv;
  endtask

  task automatic expect_ret(input logic [DW-1:0] res, input logic [4:0] rd, input logic we);
    exp_t e;
    exp_ret = exp_ret + 1'b1;
    e.res = res; e.rd = rd; e.we = we; e.ret = exp_ret;
    sb.push_back(e);
  endtask

  // Zero-wait instruction: one capture, one retirement.
  task automatic issue(input string name, input logic rw, input logic [1:0] src,
                       input logic [4:0] rd, input logic [DW-1:0] alu,
                       input logic [DW-1:0] pc4, input logic [DW-1:0] imm,
                       input logic [2:0] f3, input logic [DW-1:0] rdata,
                       input logic [DW-1:0] exp_res);
    drive(rw, src, rd, alu, pc4, imm, f3, rdata, 1'b1);
    #1 chk({name, " stall"}, StallM, 0);
    expect_ret(exp_res, rd, rw && (rd != 5'd0));
    @(posedge clk);
    #1;
  endtask

  // Monitor: any RetiredW change is one W-stage output event.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ret <= '0;
    end else if (RetiredW != prev_ret) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_retire: got ret=%0d with empty scoreboard", RetiredW);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({ResultW, RdW, RegWriteW, RetiredW} !== e) begin
          errs++;
          $display("FAIL wb_out: got res=%h rd=%0d we=%b ret=%0d expected res=%h rd=%0d we=%b ret=%0d",
                   ResultW, RdW, RegWriteW, RetiredW, e.res, e.rd, e.we, e.ret);
        end
      end
      prev_ret <= RetiredW;
    end else if (RegWriteW) begin
      checks++; errs++;
      $display("FAIL spurious_write: got we=1 rd=%0d without retirement expected we=0", RdW);
    end
  end

  initial begin
    int n;
    exp_ret = '0;
    rst_n = 1'b0;
    idle();
    // pending load presented during reset must not stall
    drive(1'b1, 2'b01, 5'd4, 32'h0, 32'h0, 32'h0, 3'b010, 32'h0, 1'b0);
    #3;
    chk("rst_stall", StallM, 0);
    chk("rst_outs", {ResultW, RdW, RegWriteW, RetiredW}, 0);
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    issue("alu", 1, 2'b00, 5'd5, 32'h1234, 0, 0, 3'b010, 0, 32'h0000_1234);
    issue("lb3", 1, 2'b01, 5'd10, 32'h103, 0, 0, 3'b000, 32'h80FF7F01, 32'hFFFF_FF80);
    issue("lbu1", 1, 2'b01, 5'd11, 32'h101, 0, 0, 3'b100, 32'h80FF7F01, 32'h0000_007F);
    issue("lh2", 1, 2'b01, 5'd12, 32'h102, 0, 0, 3'b001, 32'h80FF7F01, 32'hFFFF_80FF);
    issue("lhu0", 1, 2'b01, 5'd13, 32'h100, 0, 0, 3'b101, 32'h80FF7F01, 32'h0000_7F01);
    issue("lw", 1, 2'b01, 5'd14, 32'h100, 0, 0, 3'b010, 32'h80FF7F01, 32'h80FF_7F01);
    issue("lb2", 1, 2'b01, 5'd15, 32'h102, 0, 0, 3'b000, 32'h80FF7F01, 32'hFFFF_FFFF);
    issue("lh3", 1, 2'b01, 5'd16, 32'h103, 0, 0, 3'b001, 32'h80FF7F01, 32'hFFFF_80FF);
    issue("f3_011", 1, 2'b01, 5'd17, 32'h101, 0, 0, 3'b011, 32'h80FF7F01, 32'h80FF_7F01);
    issue("x0", 1, 2'b00, 5'd0, 32'hDEAD, 0, 0, 3'b010, 0, 32'h0000_DEAD);
    issue("jal", 1, 2'b10, 5'd1, 32'h55, 32'h0000_0104, 32'h77, 3'b010, 0, 32'h0000_0104);
    issue("lui", 1, 2'b11, 5'd8, 32'h55, 32'h104, 32'hABCD_E000, 3'b010, 0, 32'hABCD_E000);
    issue("nowr", 0, 2'b00, 5'd9, 32'h99, 0, 0, 3'b010, 0, 32'h0000_0099);
    // ValidM=0 bubbles must not retire
    idle();
    step();
    step();

    // slow LW: three wait cycles then data
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 5'd9, 32'h40, 0, 0, 3'b010, 32'hCAFE_BABE, 1'b0);
      #1;
      chk($sformatf("slow_stall%0d", i), StallM, 1);
      chk($sformatf("slow_we%0d", i), RegWriteW, 0);
      step();
    end
    MemRValidM = 1'b1;
    #1 chk("slow_release", StallM, 0);
    expect_ret(32'hCAFE_BABE, 5'd9, 1'b1);
    step();
    idle();
    step();

    // asynchronous reset mid-stream
    issue("pre_rst", 1, 2'b00, 5'd3, 32'h3333, 0, 0, 3'b010, 0, 32'h0000_3333);
    idle();
    step();
    #2 rst_n = 1'b0;
    #1 chk("midrst_outs", {ResultW, RdW, RegWriteW, RetiredW, StallM}, 0);
    exp_ret = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 17 retirements wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++)
      issue("wrap", 1, 2'b00, 5'(i + 1), 32'(i * 3), 0, 0, 3'b010, 0, 32'(i * 3));
    idle();
    step();
    chk("wrap_ret", RetiredW, 1);

    // reset while a load is waiting abandons it
    drive(1'b1, 2'b01, 5'd20, 32'h0, 0, 0, 3'b010, 32'h1111_1111, 1'b0);
    #1 chk("abort_stall_run", StallM, 1);
    step();
    chk("abort_stall_wait", StallM, 1);
    #2 rst_n = 1'b0;
    #1 chk("abort_rst_stall", StallM, 0);
    chk("abort_rst_we", RegWriteW, 0);
    exp_ret = '0;
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("abort_fsm_run", StallM, 0);
    MemRValidM = 1'b1;
    step();
    chk("abort_no_write", {RegWriteW, RetiredW}, 0);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
